// File: rtl/mips_pkg.sv
// Shared MIPS control definitions: opcode/func constants, ALU and extender codes, FSM states.
package mips_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNC_W  = 6;
    localparam int unsigned ALU_W   = 5;
    localparam int unsigned EXT_W   = 2;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned CNT_W   = 8;

    localparam logic [OP_W-1:0] OP_R    = 6'b000000;
    localparam logic [OP_W-1:0] OP_J    = 6'b000010;
    localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE  = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
    localparam logic [OP_W-1:0] OP_SLTI = 6'b001010;
    localparam logic [OP_W-1:0] OP_ORI  = 6'b001101;
    localparam logic [OP_W-1:0] OP_LUI  = 6'b001111;
    localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW   = 6'b101011;

    localparam logic [FUNC_W-1:0] FN_SLL = 6'b000000;
    localparam logic [FUNC_W-1:0] FN_SRL = 6'b000010;
    localparam logic [FUNC_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FUNC_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FUNC_W-1:0] FN_AND = 6'b100100;
    localparam logic [FUNC_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNC_W-1:0] FN_SLT = 6'b101010;

    localparam logic [ALU_W-1:0] ALU_ADD = 5'd0;
    localparam logic [ALU_W-1:0] ALU_SUB = 5'd1;
    localparam logic [ALU_W-1:0] ALU_AND = 5'd2;
    localparam logic [ALU_W-1:0] ALU_OR  = 5'd3;
    localparam logic [ALU_W-1:0] ALU_SLT = 5'd4;
    localparam logic [ALU_W-1:0] ALU_SLL = 5'd5;
    localparam logic [ALU_W-1:0] ALU_SRL = 5'd6;
    localparam logic [ALU_W-1:0] ALU_LUI = 5'd7;

    localparam logic [EXT_W-1:0] EXT_ZERO = 2'd0;
    localparam logic [EXT_W-1:0] EXT_SIGN = 2'd1;
    localparam logic [EXT_W-1:0] EXT_LUI  = 2'd2;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_MEM_ADR = 4'd2,
        ST_MEM_RD  = 4'd3,
        ST_MEM_WB  = 4'd4,
        ST_MEM_WR  = 4'd5,
        ST_EXEC    = 4'd6,
        ST_R_WB    = 4'd7,
        ST_BRANCH  = 4'd8,
        ST_JUMP    = 4'd9,
        ST_I_EXEC  = 4'd10,
        ST_I_WB    = 4'd11,
        ST_HALT    = 4'd15
    } state_t;

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Control <-> datapath/memory bundle: decoded fields and handshake in, per-state strobes out.
interface mips_mc_ctrl_if
    import mips_pkg::*;
#(
    parameter int unsigned ALUCTR_W = 5,
    parameter int unsigned EXTOP_W  = 2
);
    logic [OP_W-1:0]     op;
    logic [FUNC_W-1:0]   func;
    logic                zero;
    logic                mem_ready;
    logic                mem_req;
    logic                mem_wr;
    logic                i_or_d;
    logic                ir_wr;
    logic                pc_wr;
    logic                pc_wr_cond;
    logic [1:0]          pc_src;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [ALUCTR_W-1:0] alu_ctr;
    logic [EXTOP_W-1:0]  ext_op;
    logic                reg_wr;
    logic                reg_dst;
    logic                mem_to_reg;

    modport master (
        input  op, func, zero, mem_ready,
        output mem_req, mem_wr, i_or_d, ir_wr, pc_wr, pc_wr_cond, pc_src,
               alu_src_a, alu_src_b, alu_ctr, ext_op, reg_wr, reg_dst, mem_to_reg
    );

    modport slave (
        output op, func, zero, mem_ready,
        input  mem_req, mem_wr, i_or_d, ir_wr, pc_wr, pc_wr_cond, pc_src,
               alu_src_a, alu_src_b, alu_ctr, ext_op, reg_wr, reg_dst, mem_to_reg
    );
endinterface

// File: rtl/mips_alu_dec.sv
// Combinational op/func decode to ALU operation plus a legal-instruction flag.
module mips_alu_dec
    import mips_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [FUNC_W-1:0] func,
    output logic [ALU_W-1:0]  alu_ctr,
    output logic              legal
);

    always_comb begin
        alu_ctr = ALU_ADD;
        legal   = 1'b1;
        case (op)
            OP_R: begin
                case (func)
                    FN_ADD:  alu_ctr = ALU_ADD;
                    FN_SUB:  alu_ctr = ALU_SUB;
                    FN_AND:  alu_ctr = ALU_AND;
                    FN_OR:   alu_ctr = ALU_OR;
                    FN_SLT:  alu_ctr = ALU_SLT;
                    FN_SLL:  alu_ctr = ALU_SLL;
                    FN_SRL:  alu_ctr = ALU_SRL;
                    default: legal   = 1'b0;
                endcase
            end
            OP_LW, OP_SW, OP_J, OP_ADDI: alu_ctr = ALU_ADD;
            OP_BEQ, OP_BNE:              alu_ctr = ALU_SUB;
            OP_ORI:                      alu_ctr = ALU_OR;
            OP_LUI:                      alu_ctr = ALU_LUI;
            OP_SLTI:                     alu_ctr = ALU_SLT;
            default:                     legal   = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM: per-state datapath strobes, memory wait states,
// access watchdog and sticky illegal-instruction trap.
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned ALUCTR_W = 5,
    parameter int unsigned EXTOP_W  = 2,
    parameter int unsigned MEM_WAIT = 1,
    parameter int unsigned TMO_CYC  = 255
) (
    input  logic               clk,
    input  logic               rst,
    mips_mc_ctrl_if.master     bus,
    output logic               illegal,
    output logic               mem_tmo,
    output logic [STATE_W-1:0] state_o
);

    localparam logic             WAIT_EN  = (MEM_WAIT != 0);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);

    state_t           state, state_nxt, dec_st;
    logic [CNT_W-1:0] cnt;
    logic             hold_c, illegal_set, tmo_set, ready_c, tmo_hit_c;
    logic             dec_legal;
    logic [ALU_W-1:0] dec_alu;

    logic             mem_req_c, mem_wr_c, i_or_d_c, ir_wr_c, pc_wr_c, pc_wr_cond_c;
    logic             alu_src_a_c, reg_wr_c, reg_dst_c, mem_to_reg_c;
    logic [1:0]       pc_src_c, alu_src_b_c;
    logic [ALU_W-1:0] alu_c;
    logic [EXT_W-1:0] ext_c;

    mips_alu_dec u_alu_dec (
        .op      (bus.op),
        .func    (bus.func),
        .alu_ctr (dec_alu),
        .legal   (dec_legal)
    );

    // While rst is high the idle HALT decode keeps every strobe quiet.
    assign dec_st    = rst ? ST_HALT : state;
    assign ready_c   = !WAIT_EN || bus.mem_ready;
    assign tmo_hit_c = WAIT_EN && (cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_FETCH;
            cnt     <= '0;
            illegal <= 1'b0;
            mem_tmo <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= hold_c ? cnt + CNT_W'(1) : '0;
            if (illegal_set) illegal <= 1'b1;
            if (tmo_set)     mem_tmo <= 1'b1;
        end
    end

    always_comb begin
        state_nxt    = state;
        hold_c       = 1'b0;
        illegal_set  = 1'b0;
        tmo_set      = 1'b0;
        mem_req_c    = 1'b0;
        mem_wr_c     = 1'b0;
        i_or_d_c     = 1'b0;
        ir_wr_c      = 1'b0;
        pc_wr_c      = 1'b0;
        pc_wr_cond_c = 1'b0;
        pc_src_c     = 2'd0;
        alu_src_a_c  = 1'b0;
        alu_src_b_c  = 2'd0;
        alu_c        = ALU_ADD;
        ext_c        = EXT_ZERO;
        reg_wr_c     = 1'b0;
        reg_dst_c    = 1'b0;
        mem_to_reg_c = 1'b0;
        case (dec_st)
            ST_FETCH: begin
                mem_req_c   = 1'b1;
                alu_src_b_c = 2'd1;
                if (ready_c) begin
                    ir_wr_c   = 1'b1;
                    pc_wr_c   = 1'b1;
                    state_nxt = ST_DECODE;
                end else if (tmo_hit_c) begin
                    tmo_set   = 1'b1;
                    state_nxt = ST_HALT;
                end else begin
                    hold_c = 1'b1;
                end
            end
            ST_DECODE: begin
                alu_src_b_c = 2'd3;
                ext_c       = EXT_SIGN;
                if (!dec_legal) begin
                    illegal_set = 1'b1;
                    state_nxt   = ST_FETCH;
                end else begin
                    case (bus.op)
                        OP_R:           state_nxt = ST_EXEC;
                        OP_LW, OP_SW:   state_nxt = ST_MEM_ADR;
                        OP_BEQ, OP_BNE: state_nxt = ST_BRANCH;
                        OP_J:           state_nxt = ST_JUMP;
                        default:        state_nxt = ST_I_EXEC;
                    endcase
                end
            end
            ST_MEM_ADR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'd2;
                ext_c       = EXT_SIGN;
                state_nxt   = (bus.op == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD, ST_MEM_WR: begin
                mem_req_c = 1'b1;
                i_or_d_c  = 1'b1;
                mem_wr_c  = (dec_st == ST_MEM_WR);
                if (ready_c) begin
                    state_nxt = (dec_st == ST_MEM_WR) ? ST_FETCH : ST_MEM_WB;
                end else if (tmo_hit_c) begin
                    tmo_set   = 1'b1;
                    state_nxt = ST_HALT;
                end else begin
                    hold_c = 1'b1;
                end
            end
            ST_MEM_WB: begin
                reg_wr_c     = 1'b1;
                mem_to_reg_c = 1'b1;
                state_nxt    = ST_FETCH;
            end
            ST_EXEC: begin
                alu_src_a_c = 1'b1;
                alu_c       = dec_alu;
                state_nxt   = ST_R_WB;
            end
            ST_R_WB: begin
                reg_wr_c  = 1'b1;
                reg_dst_c = 1'b1;
                state_nxt = ST_FETCH;
            end
            ST_I_EXEC: begin
                alu_src_b_c = 2'd2;
                alu_c       = dec_alu;
                ext_c       = (bus.op == OP_ORI) ? EXT_ZERO :
                              (bus.op == OP_LUI) ? EXT_LUI  : EXT_SIGN;
                state_nxt   = ST_I_WB;
            end
            ST_I_WB: begin
                reg_wr_c  = 1'b1;
                state_nxt = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_a_c  = 1'b1;
                alu_c        = ALU_SUB;
                pc_src_c     = 2'd1;
                pc_wr_cond_c = (bus.op == OP_BEQ) ? bus.zero : !bus.zero;
                state_nxt    = ST_FETCH;
            end
            ST_JUMP: begin
                pc_wr_c   = 1'b1;
                pc_src_c  = 2'd2;
                state_nxt = ST_FETCH;
            end
            ST_HALT:  state_nxt = ST_HALT;
            default:  state_nxt = ST_FETCH;
        endcase
    end

    assign bus.mem_req    = mem_req_c;
    assign bus.mem_wr     = mem_wr_c;
    assign bus.i_or_d     = i_or_d_c;
    assign bus.ir_wr      = ir_wr_c;
    assign bus.pc_wr      = pc_wr_c;
    assign bus.pc_wr_cond = pc_wr_cond_c;
    assign bus.pc_src     = pc_src_c;
    assign bus.alu_src_a  = alu_src_a_c;
    assign bus.alu_src_b  = alu_src_b_c;
    assign bus.alu_ctr    = ALUCTR_W'(alu_c);
    assign bus.ext_op     = EXTOP_W'(ext_c);
    assign bus.reg_wr     = reg_wr_c;
    assign bus.reg_dst    = reg_dst_c;
    assign bus.mem_to_reg = mem_to_reg_c;
    assign state_o        = state;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed scoreboard bench for mips_mc_ctrl (MEM_WAIT=1, TMO_CYC=4).
module tb_mips_mc_ctrl;

    logic       clk;
    logic       rst;
    logic       illegal;
    logic       mem_tmo;
    logic [3:0] state_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      tag;
        logic       rdy;
        logic [3:0] st;
        logic       ill;
        logic       tmo;
    } ent_t;

    ent_t q[$];
    logic ill_exp = 1'b0;
    logic tmo_exp = 1'b0;

    mips_mc_ctrl_if #(.ALUCTR_W(5), .EXTOP_W(2)) bus ();

    mips_mc_ctrl #(.ALUCTR_W(5), .EXTOP_W(2), .MEM_WAIT(1), .TMO_CYC(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .illegal (illegal),
        .mem_tmo (mem_tmo),
        .state_o (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected strobe vector for a state, built from the state table of the control design.
    function automatic logic [20:0] model(input logic [3:0] st, input logic [5:0] op,
                                          input logic [5:0] fn, input logic z, input logic r);
        logic       mreq, mwr, iod, irw, pcw, pcwc, sa, rw, rd, m2r;
        logic [1:0] ps, sb, ex;
        logic [4:0] alu;
        {mreq, mwr, iod, irw, pcw, pcwc, sa, rw, rd, m2r} = '0;
        ps = 2'd0; sb = 2'd0; ex = 2'd0; alu = 5'd0;
        case (st)
            4'd0:  begin mreq = 1'b1; sb = 2'd1; irw = r; pcw = r; end
            4'd1:  begin sb = 2'd3; ex = 2'd1; end
            4'd2:  begin sa = 1'b1; sb = 2'd2; ex = 2'd1; end
            4'd3:  begin mreq = 1'b1; iod = 1'b1; end
            4'd4:  begin rw = 1'b1; m2r = 1'b1; end
            4'd5:  begin mreq = 1'b1; iod = 1'b1; mwr = 1'b1; end
            4'd6:  begin
                sa = 1'b1;
                case (fn)
                    6'b100010: alu = 5'd1;
                    6'b100100: alu = 5'd2;
                    6'b100101: alu = 5'd3;
                    6'b101010: alu = 5'd4;
                    6'b000000: alu = 5'd5;
                    6'b000010: alu = 5'd6;
                    default:   alu = 5'd0;
                endcase
            end
            4'd7:  begin rw = 1'b1; rd = 1'b1; end
            4'd8:  begin sa = 1'b1; alu = 5'd1; ps = 2'd1; pcwc = (op == 6'b000100) ? z : !z; end
            4'd9:  begin pcw = 1'b1; ps = 2'd2; end
            4'd10: begin
                sb = 2'd2;
                case (op)
                    6'b001101: begin ex = 2'd0; alu = 5'd3; end
                    6'b001111: begin ex = 2'd2; alu = 5'd7; end
                    6'b001010: begin ex = 2'd1; alu = 5'd4; end
                    default:   begin ex = 2'd1; alu = 5'd0; end
                endcase
            end
            4'd11: rw = 1'b1;
            default: ;
        endcase
        return {mreq, mwr, iod, irw, pcw, pcwc, ps, sa, sb, alu, ex, rw, rd, m2r};
    endfunction

    function automatic logic [20:0] observed();
        return {bus.mem_req, bus.mem_wr, bus.i_or_d, bus.ir_wr, bus.pc_wr, bus.pc_wr_cond,
                bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.alu_ctr, bus.ext_op,
                bus.reg_wr, bus.reg_dst, bus.mem_to_reg};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic r, input logic [3:0] st);
        ent_t e;
        e.tag = tag; e.rdy = r; e.st = st; e.ill = ill_exp; e.tmo = tmo_exp;
        q.push_back(e);
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        bus.op = op; bus.func = fn; bus.zero = z;
    endtask

    // Pop one entry per cycle: drive its mem_ready, then compare against the DUT mid-cycle.
    task automatic drain();
        ent_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            bus.mem_ready = e.rdy;
            #3;
            chk({e.tag, "/state"},   32'(state_o),  32'(e.st));
            chk({e.tag, "/strobes"}, 32'(observed()),
                32'(model(e.st, bus.op, bus.func, bus.zero, e.rdy)));
            chk({e.tag, "/illegal"}, 32'(illegal),  32'(e.ill));
            chk({e.tag, "/mem_tmo"}, 32'(mem_tmo),  32'(e.tmo));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.mem_ready = 1'b0;
        set_instr(6'b100011, 6'b000000, 1'b0);

        repeat (2) begin
            @(posedge clk);
            #4;
            chk("reset/state",   32'(state_o),    32'd0);
            chk("reset/strobes", 32'(observed()), 32'd0);
            chk("reset/illegal", 32'(illegal),    32'd0);
            chk("reset/mem_tmo", 32'(mem_tmo),    32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        // lw with two fetch wait states, then ready on the first cycle of each access
        set_instr(6'b100011, 6'b000000, 1'b0);
        push("lw_f", 1'b0, 4'd0); push("lw_f", 1'b0, 4'd0); push("lw_f", 1'b1, 4'd0);
        push("lw_d", 1'b1, 4'd1); push("lw_a", 1'b1, 4'd2); push("lw_r", 1'b1, 4'd3);
        push("lw_wb", 1'b0, 4'd4);
        drain();

        set_instr(6'b000000, 6'b100000, 1'b0);
        push("add_f", 1'b1, 4'd0); push("add_d", 1'b0, 4'd1);
        push("add_e", 1'b0, 4'd6); push("add_wb", 1'b0, 4'd7);
        drain();

        set_instr(6'b000000, 6'b100010, 1'b0);
        push("sub_f", 1'b1, 4'd0); push("sub_d", 1'b0, 4'd1);
        push("sub_e", 1'b0, 4'd6); push("sub_wb", 1'b0, 4'd7);
        drain();

        set_instr(6'b000100, 6'b000000, 1'b1);
        push("beq_f", 1'b1, 4'd0); push("beq_d", 1'b0, 4'd1); push("beq_b", 1'b0, 4'd8);
        drain();

        set_instr(6'b000101, 6'b000000, 1'b1);
        push("bne_f", 1'b1, 4'd0); push("bne_d", 1'b0, 4'd1); push("bne_b", 1'b0, 4'd8);
        drain();

        set_instr(6'b000010, 6'b000000, 1'b0);
        push("j_f", 1'b1, 4'd0); push("j_d", 1'b0, 4'd1); push("j_j", 1'b0, 4'd9);
        drain();

        set_instr(6'b001101, 6'b000000, 1'b0);
        push("ori_f", 1'b1, 4'd0); push("ori_d", 1'b0, 4'd1);
        push("ori_x", 1'b0, 4'd10); push("ori_wb", 1'b0, 4'd11);
        drain();

        set_instr(6'b001111, 6'b000000, 1'b0);
        push("lui_f", 1'b1, 4'd0); push("lui_d", 1'b0, 4'd1);
        push("lui_x", 1'b0, 4'd10); push("lui_wb", 1'b0, 4'd11);
        drain();

        // unknown opcode traps back to FETCH; illegal then stays set
        set_instr(6'b111111, 6'b000000, 1'b0);
        push("ill_f", 1'b1, 4'd0); push("ill_d", 1'b0, 4'd1);
        ill_exp = 1'b1;
        drain();

        // sw whose mem_ready lands exactly on the watchdog limit cycle completes normally
        set_instr(6'b101011, 6'b000000, 1'b0);
        push("swl_f", 1'b1, 4'd0); push("swl_d", 1'b0, 4'd1); push("swl_a", 1'b0, 4'd2);
        push("swl_w", 1'b0, 4'd5); push("swl_w", 1'b0, 4'd5); push("swl_w", 1'b0, 4'd5);
        push("swl_w", 1'b1, 4'd5);
        drain();

        // sw with no mem_ready: four waiting cycles, then HALT with mem_tmo
        push("swt_f", 1'b1, 4'd0); push("swt_d", 1'b0, 4'd1); push("swt_a", 1'b0, 4'd2);
        push("swt_w", 1'b0, 4'd5); push("swt_w", 1'b0, 4'd5); push("swt_w", 1'b0, 4'd5);
        push("swt_w", 1'b0, 4'd5);
        tmo_exp = 1'b1;
        push("halt", 1'b0, 4'd15); push("halt", 1'b1, 4'd15);
        drain();

        rst = 1'b1;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #3;
        chk("rec_rst/state",   32'(state_o),    32'd0);
        chk("rec_rst/strobes", 32'(observed()), 32'd0);
        chk("rec_rst/illegal", 32'(illegal),    32'd0);
        chk("rec_rst/mem_tmo", 32'(mem_tmo),    32'd0);
        rst = 1'b0;
        #1;
        chk("rec_fetch/state",   32'(state_o),    32'd0);
        chk("rec_fetch/strobes", 32'(observed()),
            32'(model(4'd0, bus.op, bus.func, bus.zero, 1'b0)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
